// File: rtl/wb_pkg.sv
// Shared widths and types for the writeback arbiter slice.
package wb_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 1 << ADDR_W;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_BUF,
    SRC_BYP
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Small in-order buffer for multi-cycle results; pointers wrap modulo DEPTH.
module wb_skid_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  wb_entry_t din,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and multi-cycle result streams onto the single
// RF write port, with anti-starvation bubbles and a pending-write scoreboard.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [ADDR_W-1:0]        alu_dest,
  input  logic [DATA_W-1:0]        alu_data,
  input  logic                     mc_issue,
  input  logic [ADDR_W-1:0]        mc_issue_dest,
  input  logic                     mc_valid,
  output logic                     mc_ready,
  input  logic [ADDR_W-1:0]        mc_dest,
  input  logic [DATA_W-1:0]        mc_data,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        dest_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic                     alu_stall,
  output logic                     err
);

  localparam int unsigned NR    = 1 << ADDR_W;
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  wb_src_e          sel;
  wb_entry_t        sel_entry;
  wb_entry_t        mc_entry;
  wb_entry_t        head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [CNT_W-1:0] starve_cnt;
  logic [NR-1:0]    busy_nxt;
  logic             err_nxt;

  assign mc_ready = !full;
  assign mc_entry = '{dest: mc_dest, data: mc_data};

  always_comb begin
    sel       = SRC_NONE;
    sel_entry = '0;
    if (alu_valid) begin
      sel       = SRC_ALU;
      sel_entry = '{dest: alu_dest, data: alu_data};
    end else if (!empty) begin
      sel       = SRC_BUF;
      sel_entry = head;
    end else if (mc_valid) begin
      sel       = SRC_BYP;
      sel_entry = mc_entry;
    end
  end

  assign push = mc_valid && mc_ready && (sel != SRC_BYP);
  assign pop  = (sel == SRC_BUF);

  wb_skid_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (mc_entry),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  // Clear for the retiring multi-cycle result is applied first so a same-cycle issue wins.
  always_comb begin
    busy_nxt = busy;
    if (sel == SRC_BUF || sel == SRC_BYP) busy_nxt[sel_entry.dest] = 1'b0;
    if (mc_issue && mc_issue_dest != '0)  busy_nxt[mc_issue_dest] = 1'b1;
    err_nxt = err
            | (alu_valid && alu_stall)
            | (alu_valid && alu_dest != '0 && busy[alu_dest])
            | (mc_issue && mc_issue_dest != '0 && busy[mc_issue_dest]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en     <= 1'b0;
      dest_addr <= '0;
      wr_data   <= '0;
      busy      <= '0;
      err       <= 1'b0;
    end else begin
      wr_en <= (sel != SRC_NONE) && (sel_entry.dest != '0);
      if (sel != SRC_NONE) begin
        dest_addr <= sel_entry.dest;
        wr_data   <= sel_entry.data;
      end
      busy <= busy_nxt;
      err  <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
      alu_stall  <= 1'b0;
    end else begin
      alu_stall <= 1'b0;
      if (empty || pop) begin
        starve_cnt <= '0;
      end else if (sel == SRC_ALU) begin
        if (starve_cnt == CNT_W'(STARVE_MAX - 1)) begin
          starve_cnt <= '0;
          alu_stall  <= 1'b1;
        end else begin
          starve_cnt <= starve_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [2:0]  alu_dest;
  logic [15:0] alu_data;
  logic        mc_issue;
  logic [2:0]  mc_issue_dest;
  logic        mc_valid;
  logic        mc_ready;
  logic [2:0]  mc_dest;
  logic [15:0] mc_data;
  logic        wr_en;
  logic [2:0]  dest_addr;
  logic [15:0] wr_data;
  logic [7:0]  busy;
  logic        alu_stall;
  logic        err;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  wb_arbiter #(
    .DATA_W     (16),
    .ADDR_W     (3),
    .FIFO_DEPTH (2),
    .STARVE_MAX (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_valid     (alu_valid),
    .alu_dest      (alu_dest),
    .alu_data      (alu_data),
    .mc_issue      (mc_issue),
    .mc_issue_dest (mc_issue_dest),
    .mc_valid      (mc_valid),
    .mc_ready      (mc_ready),
    .mc_dest       (mc_dest),
    .mc_data       (mc_data),
    .wr_en         (wr_en),
    .dest_addr     (dest_addr),
    .wr_data       (wr_data),
    .busy          (busy),
    .alu_stall     (alu_stall),
    .err           (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; alu_dest = 0; alu_data = 0;
    mc_issue = 0; mc_issue_dest = 0;
    mc_valid = 0; mc_dest = 0; mc_data = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  initial begin
    // 1. reset with junk inputs
    rst = 1;
    alu_valid = 1; alu_dest = 3; alu_data = 16'hDEAD;
    mc_issue = 1; mc_issue_dest = 4;
    mc_valid = 1; mc_dest = 5; mc_data = 16'hFACE;
    tick(); tick();
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mc_ready", mc_ready, 1);
    chk("rst_err", err, 0);
    chk("rst_stall", alu_stall, 0);
    idle(); rst = 0;
    tick();
    chk("post_rst_wr_en", wr_en, 0);

    // 2. ALU only
    alu_valid = 1; alu_dest = 3; alu_data = 16'h1234;
    tick();
    chk("alu_wr_en", wr_en, 1);
    chk("alu_dest", dest_addr, 3);
    chk("alu_data", wr_data, 16'h1234);
    alu_dest = 0; alu_data = 16'h5555;
    tick();
    chk("alu_r0_wr_en", wr_en, 0);
    idle();
    tick();
    chk("idle_wr_en", wr_en, 0);

    // 3. bypass + scoreboard
    mc_issue = 1; mc_issue_dest = 5;
    tick();
    chk("issue_busy", busy, 8'h20);
    idle();
    tick();
    chk("busy_hold", busy, 8'h20);
    mc_valid = 1; mc_dest = 5; mc_data = 16'hBEEF;
    chk("byp_ready", mc_ready, 1);
    tick();
    chk("byp_wr_en", wr_en, 1);
    chk("byp_dest", dest_addr, 5);
    chk("byp_data", wr_data, 16'hBEEF);
    chk("byp_busy_clr", busy, 8'h00);
    chk("byp_not_pushed", mc_ready, 1);
    idle();
    tick();
    chk("byp_after_wr_en", wr_en, 0);

    // 4. contention and starvation bubble
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1; alu_dest = 1; alu_data = 16'hA000 + 16'(i);
      mc_valid = 1;
      if (i == 0)      begin mc_dest = 6; mc_data = 16'h6001; end
      else if (i == 1) begin mc_dest = 7; mc_data = 16'h7002; end
      else             begin mc_dest = 3; mc_data = 16'h3003; end
      tick();
      chk($sformatf("cont_alu_data_%0d", i), wr_data, 16'hA000 + 16'(i));
      chk($sformatf("cont_stall_%0d", i), alu_stall, (i == 4) ? 1 : 0);
      if (i >= 1) chk($sformatf("cont_ready_%0d", i), mc_ready, 0);
    end
    alu_valid = 0;
    tick();
    chk("head0_wr_en", wr_en, 1);
    chk("head0_dest", dest_addr, 6);
    chk("head0_data", wr_data, 16'h6001);
    chk("head0_stall_off", alu_stall, 0);
    chk("head0_ready", mc_ready, 1);
    tick();
    chk("head1_dest", dest_addr, 7);
    chk("head1_data", wr_data, 16'h7002);
    mc_valid = 0;
    tick();
    chk("head2_dest", dest_addr, 3);
    chk("head2_data", wr_data, 16'h3003);
    tick();
    chk("drained_wr_en", wr_en, 0);
    chk("cont_no_err", err, 0);

    // 5a. ALU write during stall
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1; alu_dest = 1; alu_data = 16'hB000 + 16'(i);
      mc_valid = (i < 2);
      mc_dest = (i == 0) ? 3'd6 : 3'd7;
      mc_data = (i == 0) ? 16'h6100 : 16'h7101;
      tick();
    end
    mc_valid = 0;
    chk("v_stall", alu_stall, 1);
    chk("v_err_before", err, 0);
    alu_data = 16'hBAD0;
    tick();
    chk("v_stall_err", err, 1);
    chk("v_stall_alu_wins", wr_data, 16'hBAD0);
    chk("v_stall_off", alu_stall, 0);
    alu_valid = 0;
    tick();
    chk("v_pop0", wr_data, 16'h6100);
    tick();
    chk("v_pop1", wr_data, 16'h7101);
    tick();
    chk("v_sticky", err, 1);
    do_reset();
    tick();
    chk("v_rst_err", err, 0);

    // 5b. WAW against pending multi-cycle write
    mc_issue = 1; mc_issue_dest = 2;
    tick();
    mc_issue = 0;
    chk("waw_busy", busy, 8'h04);
    alu_valid = 1; alu_dest = 2; alu_data = 16'h2020;
    tick();
    chk("waw_err", err, 1);
    chk("waw_wr_en", wr_en, 1);
    chk("waw_data", wr_data, 16'h2020);
    do_reset();
    tick();
    chk("waw_rst_err", err, 0);

    // 5c. reissue to busy register, then set-wins on same-cycle clear
    mc_issue = 1; mc_issue_dest = 4;
    tick();
    chk("re_no_err", err, 0);
    tick();
    chk("re_err", err, 1);
    chk("re_busy", busy, 8'h10);
    mc_issue_dest = 5;
    tick();
    chk("sw_busy_pre", busy, 8'h30);
    mc_valid = 1; mc_dest = 5; mc_data = 16'h5A5A;
    tick();
    chk("sw_wr_en", wr_en, 1);
    chk("sw_busy", busy, 8'h30);
    idle();
    tick(); tick();
    chk("re_sticky", err, 1);
    do_reset();
    chk("re_rst_err", err, 0);
    chk("re_rst_busy", busy, 0);

    // 6. reset mid-operation
    mc_issue = 1; mc_issue_dest = 2;
    tick();
    mc_issue_dest = 3;
    tick();
    mc_issue = 0;
    chk("mid_busy", busy, 8'h0C);
    alu_valid = 1; alu_dest = 1; alu_data = 16'hC000;
    mc_valid = 1; mc_dest = 2; mc_data = 16'h2222;
    tick();
    mc_dest = 3; mc_data = 16'h3333;
    tick();
    chk("mid_full", mc_ready, 0);
    do_reset();
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", mc_ready, 1);
    tick();
    chk("mid_no_spur0", wr_en, 0);
    tick();
    chk("mid_no_spur1", wr_en, 0);
    chk("mid_busy_zero", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
